// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, default memory timeout, register-index width and the
// bundle of pipeline control outputs.
package pipe_ctrl_pkg;

   localparam int REG_IDX_W       = 5;
   localparam int DEF_MEM_TIMEOUT = 15;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } ctrlState_t;

   typedef struct packed {
      logic pcWrite;
      logic ifIdWrite;
      logic ifIdFlush;
      logic idExWrite;
      logic idExFlush;
      logic exMemWrite;
      logic memWbBubble;
      logic error;
   } ctrlOut_t;

   // Normal flow: every stage register advances, nothing squashed.
   function automatic ctrlOut_t runDefaults();
      ctrlOut_t c;
      c             = '0;
      c.pcWrite     = 1'b1;
      c.ifIdWrite   = 1'b1;
      c.idExWrite   = 1'b1;
      c.exMemWrite  = 1'b1;
      return c;
   endfunction

   // Whole pipeline held, MEM_WB fed a bubble.
   function automatic ctrlOut_t freezeAll();
      ctrlOut_t c;
      c             = '0;
      c.memWbBubble = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the instruction in EX is a load whose
// destination (other than $zero) is a source of the instruction in ID.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] rs,
   input  logic [REG_IDX_W-1:0] rt,
   input  logic                 exMemRead,
   input  logic [REG_IDX_W-1:0] exWriteRegister,
   output logic                 hazard
);

   assign hazard = exMemRead
                 && (exWriteRegister != '0)
                 && ((exWriteRegister == rs) || (exWriteRegister == rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline. Resolves, in
// priority order: memory-timeout error, multi-cycle memory wait, taken
// branch flush, load-use stall. Outputs are Mealy combinational.
// Optional performance counters are enabled with `define PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] iIdRs,
   input  logic [REG_IDX_W-1:0] iIdRt,
   input  logic                 iExMemRead,
   input  logic [REG_IDX_W-1:0] iExWriteRegister,
   input  logic                 iBranchTaken,
   input  logic                 iMemAccess,
   input  logic                 iMemReady,
   output logic                 oPcWrite,
   output logic                 oIfIdWrite,
   output logic                 oIfIdFlush,
   output logic                 oIdExWrite,
   output logic                 oIdExFlush,
   output logic                 oExMemWrite,
   output logic                 oMemWbBubble,
   output logic                 oError,
   output logic [31:0]          oStallCycles,
   output logic [31:0]          oFlushCount
);

   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   ctrlState_t       state, stateNext;
   logic [CNT_W-1:0] waitCnt, waitCntNext;
   logic             loadUse;
   logic             memStall;
   ctrlOut_t         outs;

   load_use_detect uLoadUse (
      .rs              (iIdRs),
      .rt              (iIdRt),
      .exMemRead       (iExMemRead),
      .exWriteRegister (iExWriteRegister),
      .hazard          (loadUse)
   );

   assign memStall = iMemAccess && !iMemReady;

   // State register and wait counter.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state   <= RUN;
         waitCnt <= '0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitCntNext;
      end
   end

   // Next-state logic: enter/leave the memory wait, watchdog into ERROR.
   always_comb begin
      // NOTE: defaults first so every path assigns every variable and no latch is inferred.
      stateNext   = state;
      waitCntNext = waitCnt;
      unique case (state)
         RUN: begin
            if (memStall) begin
               waitCntNext = CNT_ONE;
               stateNext   = (CNT_ONE >= TIMEOUT_VAL) ? ERROR : MEM_WAIT;
            end else begin
               waitCntNext = '0;
            end
         end
         MEM_WAIT: begin
            // The access is held in the frozen EX_MEM, so only ready matters here.
            if (iMemReady) begin
               stateNext   = RUN;
               waitCntNext = '0;
            end else begin
               waitCntNext = waitCnt + CNT_ONE;
               if (waitCntNext >= TIMEOUT_VAL) stateNext = ERROR;
            end
         end
         ERROR:   stateNext = ERROR;
         default: stateNext = RUN;
      endcase
   end

   // Output decode: reset, error, freeze, then branch flush over load-use.
   always_comb begin
      outs = runDefaults();
      if (rst) begin
         outs = freezeAll();
      end else if (state == ERROR) begin
         outs       = freezeAll();
         outs.error = 1'b1;
      end else if ((state == MEM_WAIT && !iMemReady) || (state == RUN && memStall)) begin
         outs = freezeAll();
      end else begin
         // RUN, or the MEM_WAIT cycle in which the access completes: the
         // pipeline flows again, so branch and load-use rules apply as normal.
         if (iBranchTaken) begin
            outs.ifIdFlush = 1'b1;
            outs.idExFlush = 1'b1;
         end else if (loadUse) begin
            outs.pcWrite   = 1'b0;
            outs.ifIdWrite = 1'b0;
            outs.idExFlush = 1'b1;
         end
      end
   end

   assign oPcWrite     = outs.pcWrite;
   assign oIfIdWrite   = outs.ifIdWrite;
   assign oIfIdFlush   = outs.ifIdFlush;
   assign oIdExWrite   = outs.idExWrite;
   assign oIdExFlush   = outs.idExFlush;
   assign oExMemWrite  = outs.exMemWrite;
   assign oMemWbBubble = outs.memWbBubble;
   assign oError       = outs.error;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stallCnt, flushCnt;

   // Saturating stall-cycle and branch-flush counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (!outs.pcWrite && state != ERROR && stallCnt != '1) stallCnt <= stallCnt + 32'd1;
         if (outs.ifIdFlush && flushCnt != '1)                 flushCnt <= flushCnt + 32'd1;
      end
   end

   assign oStallCycles = stallCnt;
   assign oFlushCount  = flushCnt;
`else
   assign oStallCycles = '0;
   assign oFlushCount  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a driver applies one vector
// per cycle and pushes the reference-model response; a monitor pops and
// compares on every falling edge.
module tb_pipeline_hazard_ctrl;

   localparam int TIMEOUT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] iIdRs, iIdRt, iExWriteRegister;
   logic       iExMemRead, iBranchTaken, iMemAccess, iMemReady;
   logic       oPcWrite, oIfIdWrite, oIfIdFlush, oIdExWrite, oIdExFlush;
   logic       oExMemWrite, oMemWbBubble, oError;
   logic [31:0] oStallCycles, oFlushCount;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .iIdRs            (iIdRs),
      .iIdRt            (iIdRt),
      .iExMemRead       (iExMemRead),
      .iExWriteRegister (iExWriteRegister),
      .iBranchTaken     (iBranchTaken),
      .iMemAccess       (iMemAccess),
      .iMemReady        (iMemReady),
      .oPcWrite         (oPcWrite),
      .oIfIdWrite       (oIfIdWrite),
      .oIfIdFlush       (oIfIdFlush),
      .oIdExWrite       (oIdExWrite),
      .oIdExFlush       (oIdExFlush),
      .oExMemWrite      (oExMemWrite),
      .oMemWbBubble     (oMemWbBubble),
      .oError           (oError),
      .oStallCycles     (oStallCycles),
      .oFlushCount      (oFlushCount)
   );

   typedef struct packed {
      logic        pcW, ifIdW, ifIdF, idExW, idExF, exMemW, bubble, err;
      logic [31:0] stalls, flushes;
   } exp_t;

   exp_t expQ[$];
   int   vectors     = 0;
   int   miscompares = 0;
   bit   running     = 0;

   // Reference model state: sticky error, length of current memory wait,
   // and running event totals.
   bit          mErr    = 0;
   int          mWait   = 0;
   logic [31:0] mStalls = '0;
   logic [31:0] mFlushes = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic drive(input bit r, input int rs, input int rt, input bit exRd,
                        input int exWr, input bit br, input bit acc, input bit rdy);
      exp_t e;
      bit   hazard;
      @(posedge clk);
      #1;
      rst = r; iIdRs = 5'(rs); iIdRt = 5'(rt); iExMemRead = exRd;
      iExWriteRegister = 5'(exWr); iBranchTaken = br; iMemAccess = acc; iMemReady = rdy;

      hazard = exRd && (exWr != 0) && (exWr == rs || exWr == rt);
      e = '0;
      if (r) begin
         mErr = 0; mWait = 0; mStalls = '0; mFlushes = '0;
         e.bubble = 1;
      end else if (mErr) begin
         e.bubble = 1; e.err = 1;
      end else if ((mWait > 0 || acc) && !rdy) begin
         e.bubble = 1;
         mWait++;
         if (mWait >= TIMEOUT) mErr = 1;
      end else begin
         mWait = 0;
         {e.pcW, e.ifIdW, e.idExW, e.exMemW} = 4'b1111;
         if (br) begin
            e.ifIdF = 1; e.idExF = 1;
         end else if (hazard) begin
            e.pcW = 0; e.ifIdW = 0; e.idExF = 1;
         end
      end
`ifdef PIPE_PERF_CNT_EN
      e.stalls  = mStalls;
      e.flushes = mFlushes;
`endif
      if (!r && !e.err && !e.pcW) mStalls++;
      if (e.ifIdF) mFlushes++;
      expQ.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 1, 2, 0, 0, 0, 0, 1);
   endtask

   // Monitor: one scoreboard comparison per cycle while stimulus runs.
   initial begin
      exp_t e, got;
      forever begin
         @(negedge clk);
         if (running) begin
            if (expQ.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL scoreboard: no expected entry at time %0t", $time);
            end else begin
               e   = expQ.pop_front();
               got = {oPcWrite, oIfIdWrite, oIfIdFlush, oIdExWrite, oIdExFlush,
                      oExMemWrite, oMemWbBubble, oError, oStallCycles, oFlushCount};
               vectors++;
               if (got !== e) begin
                  miscompares++;
                  $display("FAIL outputs @%0t: got pc/ifw/iff/idw/idf/exw/bub/err=%b stalls=%0d flushes=%0d expected %b stalls=%0d flushes=%0d",
                           $time, got[71:64], got.stalls, got.flushes, e[71:64], e.stalls, e.flushes);
               end
            end
         end
      end
   end

   initial begin
      rst = 1; iIdRs = 0; iIdRt = 0; iExMemRead = 0; iExWriteRegister = 0;
      iBranchTaken = 0; iMemAccess = 0; iMemReady = 1;
      running = 1;

      // Reset and normal flow.
      drive(1, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 0, 0, 1);
      idle(2);
      // Load-use on $t0, one cycle, then the load has advanced.
      drive(0, 8, 9, 1, 8, 0, 0, 1);
      drive(0, 8, 9, 0, 3, 0, 0, 1);
      // Load to $zero never stalls; rt match also detected elsewhere.
      drive(0, 0, 0, 1, 0, 0, 0, 1);
      idle(1);
      // Three-cycle memory wait, then ready.
      for (int i = 0; i < 3; i++) drive(0, 1, 2, 0, 0, 0, 1, 0);
      drive(0, 1, 2, 0, 0, 0, 1, 1);
      // Two branches; the second collides with a load-use hazard.
      drive(0, 1, 2, 0, 0, 1, 0, 1);
      drive(0, 5, 7, 1, 7, 1, 0, 1);
      idle(1);
      @(negedge clk); #1;
`ifdef PIPE_PERF_CNT_EN
      check("stall_total", oStallCycles, 32'd4);
      check("flush_total", oFlushCount, 32'd2);
`else
      check("stall_total", oStallCycles, 32'd0);
      check("flush_total", oFlushCount, 32'd0);
`endif
      // Access completing on its first cycle: no stall.
      drive(0, 1, 2, 0, 0, 0, 1, 1);
      // Branch and load-use honoured on the ready cycle of a wait.
      drive(0, 1, 2, 0, 0, 0, 1, 0);
      drive(0, 1, 2, 0, 0, 1, 1, 1);
      drive(0, 1, 2, 0, 0, 0, 1, 0);
      drive(0, 4, 6, 1, 6, 0, 1, 1);
      idle(1);
      // Timeout into sticky ERROR, then reset clears it.
      for (int i = 0; i < 6; i++) drive(0, 1, 2, 0, 0, 0, 1, 0);
      drive(0, 3, 3, 1, 3, 1, 0, 1);
      drive(1, 0, 0, 0, 0, 0, 0, 1);
      idle(2);
      // Reset in the middle of a wait abandons the access.
      drive(0, 1, 2, 0, 0, 0, 1, 0);
      drive(0, 1, 2, 0, 0, 0, 1, 0);
      drive(1, 1, 2, 0, 0, 0, 1, 0);
      idle(2);

      // Randomised traffic over a small register range to force collisions.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 99) < 3,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 9) < 4, $urandom_range(0, 3),
               $urandom_range(0, 99) < 15,
               $urandom_range(0, 9) < 3, $urandom_range(0, 3) != 0);
      end

      @(negedge clk); #1;
      running = 0;
      if (expQ.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL scoreboard: %0d expected entries left unchecked", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
